// File: rtl/pipe_if_stage_if.sv
// Signal bundle between the IF stage, the ID stage control and instruction memory.
// The slave modport is the IF stage; the master modport is its environment.
interface pipe_if_stage_if;
  logic [1:0]  pcsource;
  logic [31:0] bpc;
  logic [31:0] rpc;
  logic [31:0] jpc;
  logic        wpcir;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] dpc4;
  logic [31:0] dinst;
  logic        dvalid;

  modport master (
    output pcsource, bpc, rpc, jpc, wpcir, imem_rdata, imem_ready,
    input  imem_req, imem_addr, dpc4, dinst, dvalid
  );

  modport slave (
    input  pcsource, bpc, rpc, jpc, wpcir, imem_rdata, imem_ready,
    output imem_req, imem_addr, dpc4, dinst, dvalid
  );
endinterface

// File: rtl/pipe_if_stage.sv
// MIPS instruction-fetch stage with the IF/ID register; tolerates a multi-cycle
// instruction memory by inserting bubbles and remembering a redirect that arrives mid-wait.
module pipe_if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input logic             clock,
  input logic             resetn,
  pipe_if_stage_if.slave  bus
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] dpc4_q, dpc4_d;
  logic [31:0] dinst_q, dinst_d;
  logic        dvalid_q, dvalid_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        pend_valid_q, pend_valid_d;
  logic        req_q;

  logic [31:0] sel, target, pc4;
  logic        redirect, advance;

  always_comb begin
    sel = bus.bpc;
    unique case (bus.pcsource)
      2'b01:   sel = bus.bpc;
      2'b10:   sel = bus.rpc;
      2'b11:   sel = bus.jpc;
      default: sel = bus.bpc;
    endcase
  end

  assign target   = {sel[31:2], 2'b00};
  assign pc4      = pc_q + 32'd4;
  assign redirect = |bus.pcsource;
  assign advance  = req_q & bus.wpcir & bus.imem_ready;

  always_comb begin
    pc_d         = pc_q;
    dpc4_d       = dpc4_q;
    dinst_d      = dinst_q;
    dvalid_d     = dvalid_q;
    pend_pc_d    = pend_pc_q;
    pend_valid_d = pend_valid_q;
    if (advance) begin
      dinst_d      = bus.imem_rdata;
      dpc4_d       = pc4;
      dvalid_d     = 1'b1;
      pend_valid_d = 1'b0;
      if (redirect)          pc_d = target;
      else if (pend_valid_q) pc_d = pend_pc_q;
      else                   pc_d = pc4;
    end else if (bus.wpcir) begin
      // Fetch not back yet: bubble into ID, and park any redirect until it lands.
      dinst_d  = NOP_INST;
      dvalid_d = 1'b0;
      if (redirect) begin
        pend_pc_d    = target;
        pend_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pc_q         <= RESET_PC;
      dpc4_q       <= 32'd0;
      dinst_q      <= NOP_INST;
      dvalid_q     <= 1'b0;
      pend_pc_q    <= 32'd0;
      pend_valid_q <= 1'b0;
      req_q        <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      dpc4_q       <= dpc4_d;
      dinst_q      <= dinst_d;
      dvalid_q     <= dvalid_d;
      pend_pc_q    <= pend_pc_d;
      pend_valid_q <= pend_valid_d;
      req_q        <= 1'b1;
    end
  end

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = pc_q;
  assign bus.dpc4      = dpc4_q;
  assign bus.dinst     = dinst_q;
  assign bus.dvalid    = dvalid_q;

endmodule
